// File: rtl/hbridge_dead_time_if.sv
// H-bridge gate-drive bundle: per-track requests in, gate drives and fault out.
// master = request source (driver logic), slave = dead-time stage.
interface hbridge_dead_time_if #(
  parameter int NUM_TRACKS = 4
);
  logic [NUM_TRACKS-1:0] leftHigh;
  logic [NUM_TRACKS-1:0] leftEn;
  logic [NUM_TRACKS-1:0] rightHigh;
  logic [NUM_TRACKS-1:0] rightEn;
  logic [NUM_TRACKS-1:0] leftHiGate;
  logic [NUM_TRACKS-1:0] leftLoGate;
  logic [NUM_TRACKS-1:0] rightHiGate;
  logic [NUM_TRACKS-1:0] rightLoGate;
  logic [NUM_TRACKS-1:0] fault;

  modport master (
    output leftHigh, leftEn, rightHigh, rightEn,
    input  leftHiGate, leftLoGate, rightHiGate, rightLoGate, fault
  );

  modport slave (
    input  leftHigh, leftEn, rightHigh, rightEn,
    output leftHiGate, leftLoGate, rightHiGate, rightLoGate, fault
  );
endinterface

// File: rtl/hbridge_dead_time.sv
// Dead-time gate-drive stage for 2*NUM_TRACKS half-bridges.
// Optional latched both-high fault: define DT_FAULT_LATCH_EN.
module hbridge_dead_time #(
  parameter int NUM_TRACKS  = 4,
  parameter int DEAD_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  hbridge_dead_time_if.slave br
);

  localparam int NHB = 2 * NUM_TRACKS;
  localparam int CW  = $clog2(DEAD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {
    GAP = 2'd0,
    HI  = 2'd1,
    LO  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REQ_OFF = 2'd0,
    REQ_HI  = 2'd1,
    REQ_LO  = 2'd2
  } req_t;

  // Half-bridge h: left side for h < NUM_TRACKS, right side above.
  logic [NHB-1:0] en_w;
  logic [NHB-1:0] high_w;
  logic [NHB-1:0] force_hb;
  logic [NUM_TRACKS-1:0] force_w;

  req_t   req_w   [NHB];
  state_t state_q [NHB];
  state_t state_d [NHB];
  logic [CW-1:0] cnt_q [NHB];
  logic [CW-1:0] cnt_d [NHB];

  logic [NHB-1:0] hi_q;
  logic [NHB-1:0] hi_d;
  logic [NHB-1:0] lo_q;
  logic [NHB-1:0] lo_d;

  assign en_w     = {br.rightEn, br.leftEn};
  assign high_w   = {br.rightHigh, br.leftHigh};
  assign force_hb = {force_w, force_w};

`ifdef DT_FAULT_LATCH_EN
  logic [NUM_TRACKS-1:0] fault_q;
  logic [NUM_TRACKS-1:0] fault_d;
  logic [NUM_TRACKS-1:0] illegal_w;

  // A fault blanks the track at the very edge it is seen.
  always_comb begin
    illegal_w = br.leftEn & br.rightEn
              & br.leftHigh & br.rightHigh;
    fault_d   = fault_q | illegal_w;
    force_w   = fault_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= '0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign br.fault = fault_q;
`else
  assign force_w  = '0;
  assign br.fault = '0;
`endif

  always_comb begin
    for (int h = 0; h < NHB; h++) begin
      req_w[h] = REQ_OFF;
      if (en_w[h]) begin
        req_w[h] = high_w[h] ? REQ_HI : REQ_LO;
      end
    end
  end

  always_comb begin
    for (int h = 0; h < NHB; h++) begin
      state_d[h] = state_q[h];
      cnt_d[h]   = cnt_q[h];
      if (force_hb[h]) begin
        state_d[h] = GAP;
        cnt_d[h]   = CNT_LOAD;
      end else begin
        unique case (state_q[h])
          HI: begin
            if (req_w[h] != REQ_HI) begin
              state_d[h] = GAP;
              cnt_d[h]   = CNT_LOAD;
            end
          end
          LO: begin
            if (req_w[h] != REQ_LO) begin
              state_d[h] = GAP;
              cnt_d[h]   = CNT_LOAD;
            end
          end
          default: begin
            // Late request changes in the gap do not restart the count.
            if (cnt_q[h] != '0) begin
              cnt_d[h] = cnt_q[h] - CW'(1);
            end else if (req_w[h] == REQ_HI) begin
              state_d[h] = HI;
            end else if (req_w[h] == REQ_LO) begin
              state_d[h] = LO;
            end
          end
        endcase
      end
      hi_d[h] = (state_d[h] == HI);
      lo_d[h] = (state_d[h] == LO);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int h = 0; h < NHB; h++) begin
        state_q[h] <= GAP;
        cnt_q[h]   <= CNT_LOAD;
      end
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      for (int h = 0; h < NHB; h++) begin
        state_q[h] <= state_d[h];
        cnt_q[h]   <= cnt_d[h];
      end
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign br.leftHiGate  = hi_q[NUM_TRACKS-1:0];
  assign br.leftLoGate  = lo_q[NUM_TRACKS-1:0];
  assign br.rightHiGate = hi_q[NHB-1:NUM_TRACKS];
  assign br.rightLoGate = lo_q[NHB-1:NUM_TRACKS];

endmodule
